rv64_mem: RTL and testbench

Unified word-addressed memory that responds to the rv64 core's instruction-fetch and data-memory ports. It serves 32-bit instruction fetches and 64-bit loads/stores from one storage array, and contains a boot loader FSM. The FSM holds the core in reset while a program image streams in over a valid/ready port, then releases it. Sits beside the core in the top level, between the program-load source and the core.

---
 rtl/rv64_pkg.sv | 21 ++
 rtl/rv64_mem_if.sv | 40 ++++
 rtl/rv64_mem_loader.sv | 95 +++++++++
 rtl/rv64_mem.sv | 120 ++++++++++++
 tb/tb_rv64_mem.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv64_pkg.sv
// ============================================================================
// Module      : rv64_pkg
// Description : Shared types and constants for the rv64 memory subsystem.
//               Loader state encoding plus the core's data and instruction widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv64_pkg;

   localparam int XLEN = 64;
   localparam int ILEN = 32;

   typedef enum logic [0:0] {
      LOAD = 1'b0,
      RUN  = 1'b1
   } load_state_e;

endpackage

`default_nettype wire

// File: rtl/rv64_mem_if.sv
// ============================================================================
// Module      : rv64_mem_if
// Description : Bus bundle between the program-load source/core (master) and
//               the unified memory (slave): load stream, fetch port, data
//               port, core reset and fault flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv64_mem_if;
   import rv64_pkg::*;

   logic            load_valid;
   logic            load_ready;
   logic [ILEN-1:0] load_data;
   logic            load_last;
   logic            core_reset;
   logic [XLEN-1:0] imem_addr;
   logic [ILEN-1:0] imem_rdata;
   logic            dmem_we;
   logic [XLEN-1:0] dmem_addr;
   logic [XLEN-1:0] dmem_wdata;
   logic [XLEN-1:0] dmem_rdata;
   logic            fault;

   modport master (
      output load_valid, load_data, load_last,
      output imem_addr, dmem_we, dmem_addr, dmem_wdata,
      input  load_ready, core_reset, imem_rdata, dmem_rdata, fault
   );

   modport slave (
      input  load_valid, load_data, load_last,
      input  imem_addr, dmem_we, dmem_addr, dmem_wdata,
      output load_ready, core_reset, imem_rdata, dmem_rdata, fault
   );

endinterface

`default_nettype wire

// File: rtl/rv64_mem_loader.sv
// ============================================================================
// Module      : rv64_mem_loader
// Description : Boot loader FSM. Holds the core in reset while the program
//               image streams in, counts 32-bit beats, and issues half-word
//               write requests to the memory array. Beats past the end of
//               the array are accepted but flagged as overflow instead of
//               written.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv64_mem_loader
   import rv64_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  wire logic                           clk,
   input  wire logic                           reset,
   input  wire logic                           load_valid,
   input  wire logic [ILEN-1:0]                load_data,
   input  wire logic                           load_last,
   output logic                                load_ready,
   output logic                                core_reset,
   output load_state_e                         state,
   output logic                                wr_en,
   output logic [$clog2(DEPTH_WORDS)-1:0]      wr_idx,
   output logic                                wr_hi,
   output logic [ILEN-1:0]                     wr_data,
   output logic                                overflow
);

   localparam int          AW           = $clog2(DEPTH_WORDS);
   localparam logic [32:0] c_beat_limit = 33'(2 * DEPTH_WORDS);

   load_state_e r_state;
   load_state_e w_next_state;
   logic [31:0] r_cnt;
   logic        r_core_reset;
   logic        w_accept;
   logic        w_in_range;

   assign w_accept   = load_valid && load_ready;
   assign w_in_range = ({1'b0, r_cnt} < c_beat_limit);
   assign wr_idx     = r_cnt[AW:1];
   assign wr_hi      = r_cnt[0];
   assign wr_data    = load_data;
   assign state      = r_state;
   assign core_reset = r_core_reset;

   // State register, beat counter and registered core reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= LOAD;
         r_cnt        <= 32'd0;
         r_core_reset <= 1'b1;
      end else begin
         r_state      <= w_next_state;
         r_core_reset <= (w_next_state == LOAD);
         // Saturate so a runaway stream can never wrap back onto word 0
         if (w_accept && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 32'd1;
         end
      end
   end

   // Next state, handshake and write-request decode
   always_comb begin
      w_next_state = r_state;
      load_ready   = 1'b0;
      wr_en        = 1'b0;
      overflow     = 1'b0;
      case (r_state)
         LOAD: begin
            // Not ready during the reset cycle itself
            load_ready = !reset;
            if (w_accept) begin
               wr_en    = w_in_range;
               overflow = !w_in_range;
               if (load_last) begin
                  w_next_state = RUN;
               end
            end
         end
         RUN: begin
            w_next_state = RUN;
         end
         default: begin
            w_next_state = LOAD;
         end
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/rv64_mem.sv
// ============================================================================
// Module      : rv64_mem
// Description : Unified 64-bit word memory serving 32-bit instruction fetch
//               and 64-bit load/store with combinational reads, plus the
//               boot loader that fills it before releasing the core.
//               Optional macro RV64_MEM_FAULT_EN enables the sticky fault
//               flag and illegal-access detection; without it addresses
//               wrap and misalignment is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv64_mem
   import rv64_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input  wire logic  clk,
   input  wire logic  reset,
   rv64_mem_if.slave  bus
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [XLEN-1:0] r_mem [DEPTH_WORDS];

   load_state_e     w_state;
   logic            w_wr_en;
   logic [AW-1:0]   w_wr_idx;
   logic            w_wr_hi;
   logic [ILEN-1:0] w_wr_data;
   logic            w_overflow;
   logic            w_run;
   logic [AW-1:0]   w_d_idx;
   logic [AW-1:0]   w_i_idx;
   logic [XLEN-1:0] w_d_word;
   logic [XLEN-1:0] w_i_word;
   logic [ILEN-1:0] w_i_half;
   logic            w_store;

   rv64_mem_loader #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_loader (
      .clk        (clk),
      .reset      (reset),
      .load_valid (bus.load_valid),
      .load_data  (bus.load_data),
      .load_last  (bus.load_last),
      .load_ready (bus.load_ready),
      .core_reset (bus.core_reset),
      .state      (w_state),
      .wr_en      (w_wr_en),
      .wr_idx     (w_wr_idx),
      .wr_hi      (w_wr_hi),
      .wr_data    (w_wr_data),
      .overflow   (w_overflow)
   );

   assign w_run    = (w_state == RUN);
   assign w_d_idx  = bus.dmem_addr[AW+2:3];
   assign w_i_idx  = bus.imem_addr[AW+2:3];
   assign w_d_word = r_mem[w_d_idx];
   assign w_i_word = r_mem[w_i_idx];
   assign w_i_half = bus.imem_addr[2] ? w_i_word[63:32] : w_i_word[31:0];

`ifdef RV64_MEM_FAULT_EN
   logic w_d_bad;
   logic w_i_oor;
   logic w_i_bad;
   logic r_fault;

   // Any address bit above the array span means out of range
   assign w_d_bad = (|bus.dmem_addr[XLEN-1:AW+3]) || (|bus.dmem_addr[2:0]) ||
                    (bus.dmem_we && !w_run);
   assign w_i_oor = |bus.imem_addr[XLEN-1:AW+3];
   assign w_i_bad = w_i_oor || (|bus.imem_addr[1:0]);

   assign bus.dmem_rdata = w_d_bad ? '0 : w_d_word;
   assign bus.imem_rdata = w_i_oor ? '0 : w_i_half;
   assign w_store        = bus.dmem_we && w_run && !w_d_bad;
   assign bus.fault      = r_fault;

   // Sticky fault flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fault <= 1'b0;
      end else if (w_d_bad || w_i_bad || w_overflow) begin
         r_fault <= 1'b1;
      end
   end
`else
   logic w_unused;

   // Upper and low address bits are deliberately ignored: addresses wrap
   assign w_unused = ^{bus.dmem_addr[XLEN-1:AW+3], bus.dmem_addr[2:0],
                       bus.imem_addr[XLEN-1:AW+3], bus.imem_addr[1:0],
                       w_overflow};

   assign bus.dmem_rdata = w_d_word;
   assign bus.imem_rdata = w_i_half;
   assign w_store        = bus.dmem_we && w_run;
   assign bus.fault      = 1'b0;
`endif

   // Storage write port: loader half-words in LOAD, full stores in RUN
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         if (w_wr_hi) begin
            r_mem[w_wr_idx][63:32] <= w_wr_data;
         end else begin
            r_mem[w_wr_idx][31:0]  <= w_wr_data;
         end
      end else if (w_store) begin
         r_mem[w_d_idx] <= bus.dmem_wdata;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_rv64_mem.sv
// ============================================================================
// Module      : tb_rv64_mem
// Description : Self-checking bench for rv64_mem. Two instances (1024 and 4
//               words) are driven with directed vectors; a behavioural
//               memory/loader model is checked against both every cycle,
//               alongside hand-computed literal expectations. Expectations
//               follow RV64_MEM_FAULT_EN when it is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv64_mem;

`ifdef RV64_MEM_FAULT_EN
   localparam bit FE = 1'b1;
`else
   localparam bit FE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst0, rst1;
   always #5 clk = ~clk;

   rv64_mem_if bus0 ();
   rv64_mem_if bus1 ();

   rv64_mem #(.DEPTH_WORDS(1024)) u_dut0 (.clk(clk), .reset(rst0), .bus(bus0.slave));
   rv64_mem #(.DEPTH_WORDS(4))    u_dut1 (.clk(clk), .reset(rst1), .bus(bus1.slave));

   int n_chk = 0;
   int n_err = 0;
   bit started = 1'b0;

   // ---------------- behavioural model ----------------
   int              dep [2] = '{1024, 4};
   logic [63:0]     mm   [2][1024];
   logic [63:0]     mk   [2][1024];   // bits known to hold written data
   bit              mrun [2];
   bit              mflt [2];
   longint unsigned mcnt [2];

   initial begin
      for (int k = 0; k < 2; k++)
         for (int w = 0; w < 1024; w++) begin
            mm[k][w] = '0;
            mk[k][w] = '0;
         end
   end

   function automatic bit d_bad(int k, bit we, logic [63:0] a);
      return FE && ((a[2:0] != 3'd0) || (a >= 64'(dep[k]) * 8) || (we && !mrun[k]));
   endfunction

   function automatic bit i_bad(int k, logic [63:0] a);
      return FE && ((a >= 64'(dep[k]) * 8) || (a[1:0] != 2'd0));
   endfunction

   task automatic mstep(int k, bit rst, bit lv, logic [31:0] ld, bit ll,
                        bit we, logic [63:0] da, logic [63:0] wd, logic [63:0] ia);
      int wi;
      bit nf;
      bit db;
      if (rst) begin
         mrun[k] = 0; mcnt[k] = 0; mflt[k] = 0;
         return;
      end
      nf = mflt[k];
      db = d_bad(k, we, da);
      if (db || i_bad(k, ia)) nf = 1;
      if (!mrun[k]) begin
         if (lv) begin
            if (mcnt[k] < longint'(2 * dep[k])) begin
               wi = int'(mcnt[k] / 2);
               if (mcnt[k] % 2 == 1) begin
                  mm[k][wi][63:32] = ld; mk[k][wi][63:32] = '1;
               end else begin
                  mm[k][wi][31:0] = ld;  mk[k][wi][31:0] = '1;
               end
            end else if (FE) begin
               nf = 1;
            end
            mcnt[k]++;
            if (ll) mrun[k] = 1;
         end
      end else if (we && !db) begin
         wi = int'((da >> 3) % 64'(dep[k]));
         mm[k][wi] = wd; mk[k][wi] = '1;
      end
      mflt[k] = nf;
   endtask

   always @(posedge clk) begin
      mstep(0, rst0, bus0.load_valid, bus0.load_data, bus0.load_last,
            bus0.dmem_we, bus0.dmem_addr, bus0.dmem_wdata, bus0.imem_addr);
      mstep(1, rst1, bus1.load_valid, bus1.load_data, bus1.load_last,
            bus1.dmem_we, bus1.dmem_addr, bus1.dmem_wdata, bus1.imem_addr);
   end

   // ---------------- checking ----------------
   task automatic chkm(string nm, logic [63:0] got, logic [63:0] exp, logic [63:0] m);
      n_chk++;
      if (((got ^ exp) & m) !== 64'd0) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (mask %h)", nm, got, exp, m);
      end
   endtask

   task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
      chkm(nm, got, exp, '1);
   endtask

   task automatic cmp(int k, bit rst, logic lr, logic cr, logic f,
                      logic [31:0] ir, logic [63:0] dr,
                      logic [63:0] ia, logic [63:0] da, bit we);
      int          wi;
      logic [63:0] ew, em;
      chk($sformatf("m%0d_load_ready", k), 64'(lr), 64'(!mrun[k] && !rst));
      chk($sformatf("m%0d_core_reset", k), 64'(cr), 64'(!mrun[k]));
      chk($sformatf("m%0d_fault", k),      64'(f),  64'(mflt[k]));
      if (d_bad(k, we, da)) begin
         ew = '0; em = '1;
      end else begin
         wi = int'((da >> 3) % 64'(dep[k]));
         ew = mm[k][wi]; em = mk[k][wi];
      end
      chkm($sformatf("m%0d_dmem_rdata", k), dr, ew, em);
      if (FE && (ia >= 64'(dep[k]) * 8)) begin
         ew = '0; em = '1;
      end else begin
         wi = int'((ia >> 3) % 64'(dep[k]));
         ew = ia[2] ? {32'd0, mm[k][wi][63:32]} : {32'd0, mm[k][wi][31:0]};
         em = ia[2] ? {32'd0, mk[k][wi][63:32]} : {32'd0, mk[k][wi][31:0]};
      end
      chkm($sformatf("m%0d_imem_rdata", k), {32'd0, ir}, ew, em);
   endtask

   always @(negedge clk) begin
      if (started) begin
         cmp(0, rst0, bus0.load_ready, bus0.core_reset, bus0.fault, bus0.imem_rdata,
             bus0.dmem_rdata, bus0.imem_addr, bus0.dmem_addr, bus0.dmem_we);
         cmp(1, rst1, bus1.load_ready, bus1.core_reset, bus1.fault, bus1.imem_rdata,
             bus1.dmem_rdata, bus1.imem_addr, bus1.dmem_addr, bus1.dmem_we);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic beat0(logic [31:0] d, bit last);
      bus0.load_valid = 1'b1; bus0.load_data = d; bus0.load_last = last;
      cyc();
      bus0.load_valid = 1'b0; bus0.load_last = 1'b0;
   endtask

   task automatic beat1(logic [31:0] d, bit last);
      bus1.load_valid = 1'b1; bus1.load_data = d; bus1.load_last = last;
      cyc();
      bus1.load_valid = 1'b0; bus1.load_last = 1'b0;
   endtask

   logic [31:0] prog [4] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193};

   initial begin
      rst0 = 1'b1; rst1 = 1'b1;
      bus0.load_valid = 0; bus0.load_data = 0; bus0.load_last = 0;
      bus0.imem_addr = 0; bus0.dmem_we = 0; bus0.dmem_addr = 0; bus0.dmem_wdata = 0;
      bus1.load_valid = 0; bus1.load_data = 0; bus1.load_last = 0;
      bus1.imem_addr = 0; bus1.dmem_we = 0; bus1.dmem_addr = 0; bus1.dmem_wdata = 0;

      cyc();
      started = 1'b1;
      mid();
      chk("rst_load_ready", 64'(bus0.load_ready), 64'd0);
      chk("rst_core_reset", 64'(bus0.core_reset), 64'd1);
      chk("rst_fault",      64'(bus0.fault),      64'd0);
      cyc();
      rst0 = 1'b0; rst1 = 1'b0;
      mid();
      chk("ready_after_rst", 64'(bus0.load_ready), 64'd1);
      cyc();

      // Four-beat image, back to back
      for (int i = 0; i < 4; i++) begin
         bus0.load_valid = 1'b1; bus0.load_data = prog[i]; bus0.load_last = (i == 3);
         cyc();
      end
      bus0.load_valid = 1'b0; bus0.load_last = 1'b0;
      mid();
      chk("run_core_reset", 64'(bus0.core_reset), 64'd0);
      chk("run_load_ready", 64'(bus0.load_ready), 64'd0);
      for (int i = 0; i < 4; i++) begin
         bus0.imem_addr = 64'(i * 4);
         #1;
         chk($sformatf("fetch_%0d", i), 64'(bus0.imem_rdata), 64'(prog[i]));
      end
      bus0.imem_addr = 0;
      bus0.dmem_addr = 64'h0;
      #1;
      chk("dmem_word0", bus0.dmem_rdata, 64'h00100093_00000013);
      cyc();

      // Store, then overwrite with same-cycle read
      bus0.dmem_we = 1'b1; bus0.dmem_addr = 64'h18; bus0.dmem_wdata = 64'h01234567_89ABCDEF;
      cyc();
      bus0.dmem_wdata = 64'hDEADBEEF_CAFEF00D;
      mid();
      chk("store_old_value", bus0.dmem_rdata, 64'h01234567_89ABCDEF);
      cyc();
      bus0.dmem_we = 1'b0;
      mid();
      chk("store_new_value", bus0.dmem_rdata, 64'hDEADBEEF_CAFEF00D);
      bus0.imem_addr = 64'h18; #1;
      chk("fetch_0x18", 64'(bus0.imem_rdata), 64'hCAFEF00D);
      bus0.imem_addr = 64'h1C; #1;
      chk("fetch_0x1c", 64'(bus0.imem_rdata), 64'hDEADBEEF);
      bus0.imem_addr = 0; bus0.dmem_addr = 0;
      cyc();

      // Reset in the middle of a load
      rst0 = 1'b1; cyc(); rst0 = 1'b0;
      beat0(32'hB0000001, 1'b0);
      beat0(32'hB0000002, 1'b0);
      beat0(32'hB0000003, 1'b0);
      rst0 = 1'b1;
      mid();
      chk("midload_core_reset_a", 64'(bus0.core_reset), 64'd1);
      cyc(); rst0 = 1'b0;
      mid();
      chk("midload_core_reset_b", 64'(bus0.core_reset), 64'd1);
      cyc();
      beat0(32'h11111111, 1'b1);
      mid();
      chk("reload_core_reset", 64'(bus0.core_reset), 64'd0);
      bus0.imem_addr = 64'h0; #1;
      chk("reload_w0_lo", 64'(bus0.imem_rdata), 64'h11111111);
      bus0.imem_addr = 64'h4; #1;
      chk("retained_w0_hi", 64'(bus0.imem_rdata), 64'hB0000002);
      bus0.imem_addr = 64'h8; #1;
      chk("retained_w1_lo", 64'(bus0.imem_rdata), 64'hB0000003);
      bus0.imem_addr = 0;
      cyc();

      // Small instance: overflow beats
      for (int i = 0; i < 10; i++) begin
         bus1.load_valid = 1'b1; bus1.load_data = 32'hC0000000 + 32'(i); bus1.load_last = (i == 9);
         cyc();
      end
      bus1.load_valid = 1'b0; bus1.load_last = 1'b0;
      mid();
      chk("ovf_core_reset", 64'(bus1.core_reset), 64'd0);
      chk("ovf_fault",      64'(bus1.fault),      64'(FE));
      bus1.dmem_addr = 64'h0; #1;
      chk("ovf_word0", bus1.dmem_rdata, 64'hC0000001_C0000000);
      bus1.dmem_addr = 64'h18; #1;
      chk("ovf_word3", bus1.dmem_rdata, 64'hC0000007_C0000006);
      bus1.dmem_addr = 0;
      cyc();

      // Out-of-range store in RUN
      rst1 = 1'b1; cyc(); rst1 = 1'b0;
      beat1(32'h22222222, 1'b1);
      bus1.dmem_we = 1'b1; bus1.dmem_addr = 64'h20; bus1.dmem_wdata = 64'h55556666_77778888;
      mid();
      chk("oor_fault_before", 64'(bus1.fault), 64'd0);
      cyc();
      bus1.dmem_we = 1'b0; bus1.dmem_addr = 64'h0;
      mid();
      chk("oor_fault_after", 64'(bus1.fault), 64'(FE));
      chk("oor_word0", bus1.dmem_rdata, FE ? 64'hC0000001_22222222 : 64'h55556666_77778888);
      cyc();

      // Misaligned load right after reset
      rst1 = 1'b1; cyc(); rst1 = 1'b0;
      bus1.dmem_addr = 64'h3;
      mid();
      chk("mis_rdata", bus1.dmem_rdata, FE ? 64'h0 : 64'h55556666_77778888);
      chk("mis_fault_before", 64'(bus1.fault), 64'd0);
      cyc();
      bus1.dmem_addr = 64'h0;
      mid();
      chk("mis_fault_after", 64'(bus1.fault), 64'(FE));
      cyc();
      cyc();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

`default_nettype wire
